// File: rtl/flash_pkg.sv
// Shared definitions for the SPI NOR flash engines: opcodes, status bit
// position and the writer state encoding.
package flash_pkg;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_SE   = 8'h20;
  localparam logic [7:0] CMD_READ = 8'h03;

  localparam int unsigned STATUS_WIP_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREN,
    S_ERASE,
    S_PROG,
    S_GAP,
    S_POLL,
    S_CHECK,
    S_DONE
  } writer_state_t;

  // States in which a command is on the wire and chip select is low
  function automatic logic is_cmd_state(input writer_state_t s);
    return (s == S_WREN) || (s == S_ERASE) || (s == S_PROG) || (s == S_POLL);
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Two-phase SPI mode-0 bit engine. A load latches up to 64 bits (sent MSB
// first); each bit spends one cycle with sclk low (data set up) and one with
// sclk high (MISO sampled). finished is high during the last sclk-high cycle.
module spi_shift_engine
  import flash_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] tx_word,
  input  logic [6:0]  bit_count,
  input  logic        rx_en,
  input  logic        miso,
  output logic [7:0]  rx_byte,
  output logic        finished,
  output logic        sclk,
  output logic        mosi
);

  logic        active;
  logic        rx_on;
  logic [63:0] shreg;
  logic [6:0]  cnt;

  assign finished = active & sclk & (cnt == '0);

  // Bit sequencing: load, then alternate low/high phases until count runs out
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      rx_on   <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      shreg   <= '0;
      cnt     <= '0;
      rx_byte <= '0;
    end else if (load) begin
      active <= 1'b1;
      rx_on  <= rx_en;
      sclk   <= 1'b0;
      mosi   <= tx_word[63];
      shreg  <= {tx_word[62:0], 1'b0};
      cnt    <= bit_count - 7'd1;
    end else if (active) begin
      if (!sclk) begin
        sclk <= 1'b1;
        if (rx_on) begin
          rx_byte <= {rx_byte[6:0], miso};
        end
      end else begin
        sclk <= 1'b0;
        if (cnt == '0) begin
          active <= 1'b0;
          mosi   <= 1'b0;
        end else begin
          mosi  <= shreg[63];
          shreg <= {shreg[62:0], 1'b0};
          cnt   <= cnt - 7'd1;
        end
      end
    end
  end

endmodule

// File: rtl/flash_writer.sv
// SPI NOR flash word programmer: WREN, PAGE PROGRAM of one 32-bit word
// (little-endian byte order), then RDSR polling until WIP clears or the poll
// limit is reached (sticky error).
// Optional FLASH_WRITER_ERASE_EN: a write to a 4 KiB-aligned address first
// issues WREN + SECTOR ERASE and polls it to completion.
module flash_writer
  import flash_pkg::*;
#(
  parameter int unsigned CS_GAP     = 8,
  parameter logic [31:0] POLL_LIMIT = 32'd5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        writeStart,
  input  logic [23:0] writeAddress,
  input  logic [31:0] writeData,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        flashClk,
  output logic        flashMosi,
  output logic        flashCs,
  input  logic        flashMiso
);

  writer_state_t state, next_state;
  writer_state_t gap_next, gap_next_d;

  logic [23:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] gap_cnt;
  logic [31:0] poll_count;
  logic        started;
  logic        erase_pending;
  logic        erase_req;
  logic        set_error;
  logic        clear_erase;

  logic        load;
  logic [63:0] tx_word;
  logic [6:0]  bit_count;
  logic        rx_en;
  logic [7:0]  rx_byte;
  logic        finished;

`ifdef FLASH_WRITER_ERASE_EN
  assign erase_req = (writeAddress[11:0] == '0);
`else
  assign erase_req = 1'b0;
`endif

  spi_shift_engine u_engine (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .tx_word   (tx_word),
    .bit_count (bit_count),
    .rx_en     (rx_en),
    .miso      (flashMiso),
    .rx_byte   (rx_byte),
    .finished  (finished),
    .sclk      (flashClk),
    .mosi      (flashMosi)
  );

  // State register; chip select is registered from the next state so it
  // falls one cycle ahead of the first data phase and rises right after the last
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      gap_next <= S_IDLE;
      flashCs  <= 1'b1;
    end else begin
      state    <= next_state;
      gap_next <= gap_next_d;
      flashCs  <= !is_cmd_state(next_state);
    end
  end

  // Next-state logic
  always_comb begin
    next_state  = state;
    gap_next_d  = gap_next;
    set_error   = 1'b0;
    clear_erase = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (writeStart) next_state = S_WREN;
      end
      S_WREN: begin
        if (finished) begin
          next_state = S_GAP;
          gap_next_d = erase_pending ? S_ERASE : S_PROG;
        end
      end
      S_ERASE, S_PROG: begin
        if (finished) begin
          next_state = S_GAP;
          gap_next_d = S_POLL;
        end
      end
      S_GAP: begin
        if (gap_cnt + 32'd1 >= 32'(CS_GAP)) next_state = gap_next;
      end
      S_POLL: begin
        if (finished) next_state = S_CHECK;
      end
      S_CHECK: begin
        if (!rx_byte[STATUS_WIP_BIT]) begin
          if (erase_pending) begin
            clear_erase = 1'b1;
            next_state  = S_GAP;
            gap_next_d  = S_WREN;
          end else begin
            next_state = S_DONE;
          end
        end else if (poll_count >= POLL_LIMIT) begin
          set_error  = 1'b1;
          next_state = S_DONE;
        end else begin
          next_state = S_GAP;
          gap_next_d = S_POLL;
        end
      end
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs and shift-engine command selection
  always_comb begin
    tx_word   = '0;
    bit_count = '0;
    rx_en     = 1'b0;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    load      = is_cmd_state(state) && !started;
    unique case (state)
      S_WREN: begin
        tx_word   = {CMD_WREN, 56'b0};
        bit_count = 7'd8;
      end
      S_ERASE: begin
        tx_word   = {CMD_SE, addr_q, 32'b0};
        bit_count = 7'd32;
      end
      S_PROG: begin
        tx_word   = {CMD_PP, addr_q, data_q[7:0], data_q[15:8], data_q[23:16], data_q[31:24]};
        bit_count = 7'd64;
      end
      S_POLL: begin
        tx_word   = {CMD_RDSR, 56'b0};
        bit_count = 7'd16;
        rx_en     = 1'b1;
      end
      default: ;
    endcase
  end

  // Request latching, error flag, gap and poll counters
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      data_q        <= '0;
      error         <= 1'b0;
      erase_pending <= 1'b0;
      started       <= 1'b0;
      gap_cnt       <= '0;
      poll_count    <= '0;
    end else begin
      if (state == S_IDLE && writeStart) begin
        addr_q        <= writeAddress;
        data_q        <= writeData;
        error         <= 1'b0;
        erase_pending <= erase_req;
      end
      if (set_error) error <= 1'b1;
      if (clear_erase) erase_pending <= 1'b0;
      started <= is_cmd_state(state) && !finished;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 32'd1 : '0;
      if (state == S_WREN) begin
        poll_count <= '0;
      end else if (state == S_POLL && finished && poll_count < POLL_LIMIT) begin
        poll_count <= poll_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_flash_writer.sv
// Directed bench for flash_writer with a behavioural SPI NOR flash model.
module tb_flash_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        writeStart;
  logic [23:0] writeAddress;
  logic [31:0] writeData;
  logic        busy, done, error;
  logic        flashClk, flashMosi, flashCs;
  logic        flashMiso = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  flash_writer #(.CS_GAP(8), .POLL_LIMIT(32'd4)) dut (
    .clk          (clk),
    .rst          (rst),
    .writeStart   (writeStart),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .flashClk     (flashClk),
    .flashMosi    (flashMosi),
    .flashCs      (flashCs),
    .flashMiso    (flashMiso)
  );

  // ---------------- flash model (sampled mid-cycle) ----------------
  bit          hold_busy  = 1'b0;
  int unsigned busy_polls = 1;
  logic        prev_cs    = 1'b1;
  logic        prev_sclk  = 1'b0;
  int unsigned bit_cnt    = 0;
  int unsigned cs_falls   = 0;
  int unsigned rdsr_since = 0;
  int unsigned aborted    = 0;
  logic        wel        = 1'b0;
  logic [63:0] cmd_shift  = '0;
  logic [7:0]  op_cur     = '0;
  logic [63:0] pp_last    = '0;
  logic [31:0] se_last    = '0;
  logic [7:0]  op_log [$];
  logic [7:0]  mem [int];

  always @(negedge clk) begin
    logic [7:0]  status;
    logic        wip;
    logic [23:0] a;
    logic [23:0] key;
    if (prev_cs === 1'b1 && flashCs === 1'b0) begin
      bit_cnt = 0;
      op_cur  = 8'h00;
      cs_falls++;
    end
    if (flashCs === 1'b0 && prev_sclk === 1'b0 && flashClk === 1'b1) begin
      cmd_shift = {cmd_shift[62:0], flashMosi};
      bit_cnt++;
      if (bit_cnt == 8) op_cur = cmd_shift[7:0];
    end
    if (flashCs === 1'b0 && prev_sclk === 1'b1 && flashClk === 1'b0 &&
        op_cur == 8'h05 && bit_cnt >= 8 && bit_cnt < 16) begin
      wip       = hold_busy || (rdsr_since + 1 < busy_polls);
      status    = {~wip, 5'b00000, 1'b1, wip};
      flashMiso = status[7 - (bit_cnt - 8)];
    end
    if (prev_cs === 1'b0 && flashCs === 1'b1 && bit_cnt > 0) begin
      op_log.push_back(op_cur);
      case (op_cur)
        8'h06: if (bit_cnt == 8) wel = 1'b1;
        8'h02: begin
          if (bit_cnt == 64 && wel) begin
            pp_last = cmd_shift;
            a = cmd_shift[55:32];
            for (int i = 0; i < 4; i++) begin
              key = {a[23:8], a[7:0] + 8'(i)};
              mem[int'(key)] = cmd_shift[31 - 8*i -: 8];
            end
            wel = 1'b0;
            rdsr_since = 0;
          end else begin
            aborted++;
          end
        end
        8'h20: begin
          if (bit_cnt == 32 && wel) begin
            se_last = cmd_shift[31:0];
            a = cmd_shift[23:0];
            for (int j = 0; j < 4096; j++) begin
              key = {a[23:12], 12'h000} + 24'(j);
              if (mem.exists(int'(key))) mem.delete(int'(key));
            end
            wel = 1'b0;
            rdsr_since = 0;
          end else begin
            aborted++;
          end
        end
        8'h05: rdsr_since++;
        default: ;
      endcase
    end
    prev_cs   = flashCs;
    prev_sclk = flashClk;
  end

  // ---------------- protocol monitors ----------------
  int unsigned done_cnt  = 0;
  int unsigned viol_clk  = 0;
  int unsigned viol_mosi = 0;
  int unsigned hi_run    = 0;
  bit          seen_low  = 1'b0;
  logic        mon_mosi  = 1'b0;
  int unsigned gap_log [$];

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (flashCs === 1'b1 && flashClk !== 1'b0) viol_clk++;
    if (flashClk === 1'b1 && flashMosi !== mon_mosi) viol_mosi++;
    mon_mosi = flashMosi;
    if (busy !== 1'b1) begin
      hi_run   = 0;
      seen_low = 1'b0;
    end else if (flashCs === 1'b1) begin
      hi_run++;
    end else begin
      if (seen_low && hi_run > 0) gap_log.push_back(hi_run);
      hi_run   = 0;
      seen_low = 1'b1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 8'hFF;
  endfunction

  function automatic logic [31:0] read_word(input logic [23:0] a);
    logic [31:0] r = '0;
    for (int i = 3; i >= 0; i--) r = {r[23:0], mem_byte(a + 24'(i))};
    return r;
  endfunction

  function automatic logic [63:0] ops_since(input int unsigned base);
    logic [63:0] r = '0;
    for (int unsigned i = base; i < op_log.size(); i++) r = {r[55:0], op_log[i]};
    return r;
  endfunction

  task automatic pulse_start(input logic [23:0] a, input logic [31:0] d);
    @(negedge clk);
    writeAddress = a;
    writeData    = d;
    writeStart   = 1'b1;
    @(negedge clk);
    writeStart   = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", done, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned base, falls0, done0, abort0, gbase, n;
    rst = 1'b1; writeStart = 1'b0; writeAddress = '0; writeData = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_cs",    flashCs,   1);
    check_eq("rst_sclk",  flashClk,  0);
    check_eq("rst_mosi",  flashMosi, 0);
    check_eq("rst_busy",  busy,      0);
    check_eq("rst_done",  done,      0);
    check_eq("rst_error", error,     0);
    rst = 1'b0;

    // basic write, WIP clears on the third status read
    busy_polls = 3; hold_busy = 1'b0;
    base = op_log.size(); gbase = gap_log.size(); done0 = done_cnt;
    pulse_start(24'h000100, 32'hDDCCBBAA);
    check_eq("busy_after_accept", busy, 1);
    wait_done(3000);
    // start request during the DONE cycle must be dropped
    writeAddress = 24'h000500; writeData = 32'h01020304; writeStart = 1'b1;
    @(negedge clk);
    writeStart = 1'b0;
    check_eq("start_in_done_ignored", busy, 0);
    falls0 = cs_falls;
    repeat (20) @(negedge clk);
    check_eq("no_cmd_after_done", cs_falls - falls0, 0);
    check_eq("basic_op_count", op_log.size() - base, 5);
    check_eq("basic_ops", ops_since(base), 64'h0602050505);
    check_eq("basic_pp_bytes", pp_last, 64'h02000100AABBCCDD);
    check_eq("basic_error", error, 0);
    check_eq("basic_readback", read_word(24'h000100), 32'hDDCCBBAA);
    check_eq("basic_done_pulses", done_cnt - done0, 1);
    check_eq("cs_gap_min", (gap_log.size() > gbase) && (gap_log[gbase] >= 8), 1);

    // second request during PROG is ignored
    busy_polls = 2;
    base = op_log.size(); done0 = done_cnt; falls0 = cs_falls;
    pulse_start(24'h000300, 32'hA5A5A5A5);
    n = 0;
    while (cs_falls < falls0 + 2 && n < 2000) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    pulse_start(24'h000400, 32'h5A5A5A5A);
    wait_done(3000);
    repeat (100) @(negedge clk);
    check_eq("busyrej_ops", ops_since(base), 64'h06020505);
    check_eq("busyrej_op_count", op_log.size() - base, 4);
    check_eq("busyrej_first_word", read_word(24'h000300), 32'hA5A5A5A5);
    check_eq("busyrej_second_word", read_word(24'h000400), 32'hFFFFFFFF);
    check_eq("busyrej_done_pulses", done_cnt - done0, 1);

    // reset after 20 PROG bits
    busy_polls = 1;
    done0 = done_cnt; abort0 = aborted; falls0 = cs_falls;
    pulse_start(24'h000600, 32'h12345678);
    n = 0;
    while (!(cs_falls >= falls0 + 2 && bit_cnt >= 20) && n < 2000) begin @(negedge clk); n++; end
    check_eq("reached_prog_bit20", (cs_falls >= falls0 + 2) && (bit_cnt >= 20), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_cs", flashCs, 1);
    check_eq("midrst_sclk", flashClk, 0);
    check_eq("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("midrst_no_done", done_cnt - done0, 0);
    check_eq("midrst_aborted", aborted - abort0, 1);
    check_eq("midrst_not_programmed", read_word(24'h000600), 32'hFFFFFFFF);

    // poll timeout, then the next accepted start clears error
    hold_busy = 1'b1;
    base = op_log.size();
    pulse_start(24'h000200, 32'h11223344);
    wait_done(3000);
    check_eq("timeout_error", error, 1);
    check_eq("timeout_ops", ops_since(base), 64'h060205050505);
    check_eq("timeout_op_count", op_log.size() - base, 6);
    @(negedge clk);
    check_eq("timeout_idle", busy, 0);
    hold_busy = 1'b0; busy_polls = 1;
    pulse_start(24'h000204, 32'h55667788);
    check_eq("error_cleared_on_start", error, 0);
    wait_done(3000);
    check_eq("after_timeout_error", error, 0);
    check_eq("after_timeout_readback", read_word(24'h000204), 32'h55667788);

    // sector-aligned address
    busy_polls = 1;
    base = op_log.size();
    pulse_start(24'h003000, 32'hCAFEF00D);
    wait_done(4000);
    repeat (5) @(negedge clk);
`ifdef FLASH_WRITER_ERASE_EN
    check_eq("erase_ops", ops_since(base), 64'h062005060205);
    check_eq("erase_op_count", op_log.size() - base, 6);
    check_eq("erase_se_bytes", se_last, 32'h20003000);
`else
    check_eq("noerase_ops", ops_since(base), 64'h060205);
    check_eq("noerase_op_count", op_log.size() - base, 3);
`endif
    check_eq("sector_readback", read_word(24'h003000), 32'hCAFEF00D);
    base = op_log.size();
    pulse_start(24'h003004, 32'h0BADBEEF);
    wait_done(4000);
    repeat (5) @(negedge clk);
    check_eq("unaligned_ops", ops_since(base), 64'h060205);
    check_eq("unaligned_keeps_prev", read_word(24'h003000), 32'hCAFEF00D);
    check_eq("unaligned_readback", read_word(24'h003004), 32'h0BADBEEF);

    check_eq("sclk_low_while_cs_high", viol_clk, 0);
    check_eq("mosi_stable_sclk_high", viol_mosi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_writer.md
Name: flash_writer

Overview:
- SPI NOR flash programming engine. Writes one 32-bit word to a 24-bit flash address using the standard sequence:
  - WRITE ENABLE (0x06)
  - PAGE PROGRAM (0x02) with address and 4 data bytes
  - READ STATUS (0x05) polling until WIP clears
- Sits beside the flash read engine on the same flash pins; the top level muxes the pins by busy.
- Byte order matches the read path: writeData[7:0] goes to writeAddress, [15:8] to +1, [23:16] to +2, [31:24] to +3.

Parameters:
- CS_GAP, 8, clk cycles flashCs is held high between commands (minimum tSHSL).
- POLL_LIMIT, 32'd5000000, maximum status reads before the operation aborts with an error.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- writeStart  input  1  single-cycle request pulse; sampled only in IDLE
- writeAddress  input  24  flash byte address; latched on accepted writeStart
- writeData  input  32  word to program; latched on accepted writeStart
- busy  output  1  high from the cycle after acceptance until DONE exits
- done  output  1  one-cycle pulse at completion
- error  output  1  sticky timeout flag; cleared by the next accepted writeStart or by rst
- flashClk  output  1  SPI clock, mode 0, idle low
- flashMosi  output  1  SPI data out, MSB first
- flashCs  output  1  chip select, active-low
- flashMiso  input  1  SPI data in

Behaviour:
- Reset values: flashCs=1, flashClk=0, flashMosi=0, busy=0, done=0, error=0, state=IDLE, all counters 0. Reset mid-operation aborts immediately; flashCs rises on the reset cycle, so any in-flight program command is truncated. Flash ignores a partial page program.
- SPI timing: each bit takes 2 clk cycles.
  - Phase 0: flashClk=0, flashMosi=next bit.
  - Phase 1: flashClk=1; MISO is sampled on this edge (shifted in LSB-first into a byte, i.e. MSB arrives first).
- Chip select: flashCs falls in the cycle before the first phase 0 and rises the cycle after the last phase 1 of a command.
- States:
  - IDLE: waits for writeStart; latches address and data; clears error; goes to WREN.
  - WREN: shifts 8 bits of 0x06 -> GAP (next=PROG).
  - GAP: holds flashCs=1 for CS_GAP cycles, then goes to next.
  - PROG: shifts 64 bits in order: 0x02, address[23:0], data[7:0], data[15:8], data[23:16], data[31:24] -> GAP (next=POLL).
  - POLL: shifts 8 bits of 0x05, then clocks 8 more bits reading status; increments pollCount -> CHECK.
  - CHECK:
    - status[0]==0: go to DONE.
    - status[0]==1 and pollCount<POLL_LIMIT: GAP (next=POLL).
    - status[0]==1 and pollCount==POLL_LIMIT: set error, go to DONE.
  - DONE: done=1 for 1 cycle, busy=0 next cycle, returns to IDLE.
- writeStart while busy: ignored, with no queueing.
- writeStart in the same cycle as DONE: ignored; it is accepted only in IDLE.
- Page wrap: bytes crossing a 256-byte page boundary wrap within the page (flash behaviour). The block does not split the write; callers must keep 4-byte alignment.
- Counters: the bit counter is 7 bits; pollCount is 32 bits and saturates at POLL_LIMIT.

Optional Feature:
- FLASH_WRITER_ERASE_EN
  - Defined: when the latched writeAddress[11:0]==0, the sequence becomes WREN, 0x20 SECTOR ERASE + 24-bit address, GAP, then POLL until WIP clears, then the normal WREN/PROG/POLL sequence. The erase poll shares POLL_LIMIT and the error rules.
  - Undefined: no erase is ever issued; the caller must erase sectors beforehand.

Decomposition:
- Package flash_pkg holds:
  - opcodes: CMD_WREN=8'h06, CMD_PP=8'h02, CMD_RDSR=8'h05, CMD_SE=8'h20, CMD_READ=8'h03
  - the state enum for flash_writer
  - STATUS_WIP_BIT=0
- Sub-module spi_shift_engine holds the 2-phase bit engine:
  - inputs: load, 64-bit tx word, bit count, read-back enable
  - outputs: rx byte, finished pulse
  - drives flashClk and flashMosi
  - It is reusable by the read engine later.

Test Plan:
- Basic write: writeAddress=0x000100, writeData=0xDDCCBBAA, flash model clears WIP after 3 polls.
  - Expect byte 0x06, then 0x02 00 01 00 AA BB CC DD, then exactly 3 RDSR transactions, done pulse, busy low, error=0.
  - Model memory reads back 0xDDCCBBAA via the read path.
- Timeout: POLL_LIMIT=4, model holds WIP=1.
  - Expect 4 RDSR transactions, error=1, done pulse, return to IDLE.
  - The next writeStart clears error.
- Busy rejection: second writeStart pulsed 10 cycles into PROG with different data.
  - Expect it ignored; only the first word is programmed; a single done pulse.
- Reset mid-PROG: assert rst after 20 of the 64 bits.
  - Expect flashCs=1 and flashClk=0 the same cycle, busy=0, no done pulse, model reports an aborted command.
- CS timing: measure flashCs high between WREN and PROG.
  - Expect >= CS_GAP cycles; flashClk=0 whenever flashCs=1; flashMosi is stable while flashClk=1.
- ERASE_EN build, writeAddress=0x003000.
  - Expect 0x06, 0x20 00 30 00, poll loop, 0x06, PP sequence.
  - writeAddress=0x003004 produces no erase.
